// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl -- operand stack and ALU sequencer for the 4-bit RPN calculator.
//
// Accepts push-operand / apply-operator commands and keeps the operand stack.
// For each accepted operator it launches exactly one ALU operation and writes
// the result back in place of the two operands. The top of stack goes to the
// display mux.
//
// Optional feature: define ALU_TIMEOUT_EN to bound the wait for the ALU to
// TIMEOUT cycles. The TIMEOUT parameter exists only in that build. Without the
// macro, the wait is unbounded and err_timeout is tied to 0.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   cmd_valid/ready   command handshake (see below)
//   cmd_is_op         0 = push cmd_data, 1 = apply operator cmd_data[1:0]
//   cmd_data          4-bit operand or opcode
//   alu_start         one-cycle launch strobe
//   alu_opcode/a/b    opcode and operands, held from launch until the result
//   alu_done/result   result strobe and value from the ALU
//   top, depth        top of stack (0 when empty) and entries in use
//   err_overflow      sticky: push while full
//   err_underflow     sticky: operator with fewer than two entries
//   err_timeout       sticky: ALU never answered (ALU_TIMEOUT_EN only)
//   state_dbg         current sequencer state (IDLE=0, ISSUE=1, WAIT=2, WRITE=3)
//
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
// are both 1. cmd_ready is 1 only while idle. The source must hold a command,
// unchanged, until it transfers. Errors are flagged but never stall the
// interface.
module rpn_stack_ctrl #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
`ifdef ALU_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 16
`endif
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_is_op,
   input  logic [3:0]                   cmd_data,
   output logic                         alu_start,
   output logic [1:0]                   alu_opcode,
   output logic [WIDTH-1:0]             alu_a,
   output logic [WIDTH-1:0]             alu_b,
   input  logic                         alu_done,
   input  logic [WIDTH-1:0]             alu_result,
   output logic [WIDTH-1:0]             top,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         err_overflow,
   output logic                         err_underflow,
   output logic                         err_timeout,
   output logic [1:0]                   state_dbg
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] entry [DEPTH];
   logic [WIDTH-1:0] res;
   logic [IW-1:0]    push_idx, top_idx, sec_idx;
   logic             accept;
   logic             tmo_hit;

   // The indices are only used when the depth checks make them valid. So
   // truncating them to the array index width is safe.
   assign push_idx  = IW'(depth);
   assign top_idx   = IW'(depth - DW'(1));
   assign sec_idx   = IW'(depth - DW'(2));

   assign accept    = cmd_valid && (state == S_IDLE);
   assign cmd_ready = (state == S_IDLE);
   assign alu_start = (state == S_ISSUE);
   assign state_dbg = state;

   always_comb begin
      top = '0;
      if (depth != '0) top = entry[top_idx];
   end

   // ---------------- sequencer ----------------
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept && cmd_is_op && (depth >= DW'(2))) state_nx = S_ISSUE;
         S_ISSUE: state_nx = S_WAIT;
         // A result on the last allowed cycle still counts, so alu_done is
         // checked before the timeout.
         S_WAIT:  if (alu_done)     state_nx = S_WRITE;
                  else if (tmo_hit) state_nx = S_IDLE;
         S_WRITE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // ---------------- stack and ALU interface ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
         depth         <= '0;
         res           <= '0;
         alu_opcode    <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (!cmd_is_op) begin
                     if (depth < DW'(DEPTH)) begin
                        entry[push_idx] <= WIDTH'(cmd_data);
                        depth           <= depth + DW'(1);
                     end else begin
                        err_overflow <= 1'b1;
                     end
                  end else if (depth >= DW'(2)) begin
                     // Operands are captured here and held through WAIT. The
                     // stack cannot change while the operation is in flight.
                     alu_opcode <= cmd_data[1:0];
                     alu_a      <= entry[sec_idx];
                     alu_b      <= entry[top_idx];
                  end else begin
                     err_underflow <= 1'b1;
                  end
               end
            end
            S_WAIT:  if (alu_done) res <= alu_result;
            S_WRITE: begin
               entry[sec_idx] <= res;
               depth          <= depth - DW'(1);
            end
            default: ;
         endcase
      end
   end

   // ---------------- optional ALU watchdog ----------------
`ifdef ALU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt;

   // wait_cnt numbers the WAIT cycles from 0. The operation is abandoned at
   // the end of WAIT cycle number TIMEOUT-1, which leaves the stack untouched.
   assign tmo_hit = (state == S_WAIT) && !alu_done && (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state == S_ISSUE)     wait_cnt <= '0;
         else if (state == S_WAIT) wait_cnt <= wait_cnt + CW'(1);
         if (tmo_hit) err_timeout <= 1'b1;
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule
